hack_boot_loader: RTL and testbench



---
 rtl/hack_boot_pkg.sv | 36 +++
 rtl/hack_boot_word_asm.sv | 55 +++++
 rtl/hack_boot_loader.sv | 149 ++++++++++++++
 tb/tb_hack_boot_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_boot_pkg.sv
// rtl/hack_boot_pkg.sv - shared types and constants for the hack CPU boot loader
// Purpose: state encoding, default image limit and byte order used by the
//   loader FSM and its word assembler.
// Ports: none (package).
// Build option: HACK_BOOT_CHECKSUM_EN enables the CHK_HI/CHK_LO states.
package hack_boot_pkg;

  localparam int DEFAULT_PROG_WORDS = 32768;

  // Multi-byte fields on the stream (length, words, checksum) arrive MSB first.
  localparam bit HI_BYTE_FIRST = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK_HI,
    CHK_LO,
    DRAIN,
    RUN,
    ERROR
  } bootState_t;

  // States in which a load is in progress.
  function automatic logic isBusyState(input bootState_t s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO, DRAIN};
  endfunction

  // States in which the loader takes bytes from the receiver.
  function automatic logic isRxState(input bootState_t s);
    return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO};
  endfunction

endpackage

// File: rtl/hack_boot_word_asm.sv
// rtl/hack_boot_word_asm.sv - byte-pair to 16-bit word assembler with optional running sum
// Purpose: holds the first byte of a pair and presents the assembled word
//   combinationally while the second byte is on byteIn; optionally keeps a
//   modulo-2^16 sum of every completed word.
// Ports:
//   clock, reset   clock and asynchronous active-low reset
//   clear          zero the running sum
//   loadHi         capture byteIn as the first byte of the pair
//   loadLo         second byte present; add the assembled word to the sum
//   byteIn         received byte
//   word           assembled word (first byte + byteIn)
//   sum            running sum (zero unless HACK_BOOT_CHECKSUM_EN is defined)
// Build option: HACK_BOOT_CHECKSUM_EN enables the accumulator.
module hack_boot_word_asm
  import hack_boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        loadHi,
  input  logic        loadLo,
  input  logic [7:0]  byteIn,
  output logic [15:0] word,
  output logic [15:0] sum
);

  logic [7:0] hiByte;

  assign word = HI_BYTE_FIRST ? {hiByte, byteIn} : {byteIn, hiByte};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hiByte <= '0;
    end else if (loadHi) begin
      hiByte <= byteIn;
    end
  end

`ifdef HACK_BOOT_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (loadLo) begin
      sum <= sum + word;
    end
  end
`else
  logic unusedAccCtl;
  assign unusedAccCtl = clear ^ loadLo;
  assign sum = '0;
`endif

endmodule

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - hack CPU boot loader: byte stream to instruction memory, then CPU release
// Purpose: holds the CPU in reset, receives a length-prefixed image over a
//   byte stream, writes it word by word into instruction memory and then
//   releases the CPU.
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   start                one-cycle pulse that begins a (re)load when not busy
//   rx_data/rx_valid     received byte and its qualifier
//   rx_ready             byte accepted on rx_valid && rx_ready
//   rom_addr/rom_wdata   instruction memory write address / word
//   rom_we               one-cycle write strobe
//   cpu_reset            active-high reset to the CPU
//   busy/done/err        load in progress / CPU running / load rejected
// Build option: HACK_BOOT_CHECKSUM_EN appends a 16-bit checksum after the data.
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int PROG_WORDS = DEFAULT_PROG_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  bootState_t        state;
  bootState_t        nextState;
  logic              accept;
  logic [7:0]        lenHi;
  logic [15:0]       lenFull;
  logic              lenBad;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W-1:0] lastIdx;
  logic              lastWord;
  logic [15:0]       asmWord;
  logic [15:0]       asmSum;
  logic              sumClear;

  assign accept   = rx_valid && rx_ready;
  assign lenFull  = {lenHi, rx_data};
  assign lenBad   = (lenFull == 16'd0) || (32'(lenFull) > PROG_WORDS);
  // Comparing against N-1 stops the index at the last address, so a full
  // PROG_WORDS image never wraps.
  assign lastWord = (wordIdx == lastIdx);
  assign sumClear = (nextState == LEN_HI) && (state != LEN_HI);

`ifdef HACK_BOOT_CHECKSUM_EN
  logic [7:0] chkHi;
  logic       sumMatch;
  assign sumMatch = ({chkHi, rx_data} == asmSum);
`else
  logic unusedSum;
  assign unusedSum = ^asmSum;
`endif

  hack_boot_word_asm wordAsm (
    .clock  (clock),
    .reset  (reset),
    .clear  (sumClear),
    .loadHi (accept && (state == DATA_HI)),
    .loadLo (accept && (state == DATA_LO)),
    .byteIn (rx_data),
    .word   (asmWord),
    .sum    (asmSum)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = LEN_HI;
      LEN_HI:  if (accept) nextState = LEN_LO;
      LEN_LO:  if (accept) nextState = lenBad ? ERROR : DATA_HI;
      DATA_HI: if (accept) nextState = DATA_LO;
`ifdef HACK_BOOT_CHECKSUM_EN
      DATA_LO: if (accept) nextState = lastWord ? CHK_HI : DATA_HI;
      CHK_HI:  if (accept) nextState = CHK_LO;
      CHK_LO:  if (accept) nextState = sumMatch ? DRAIN : ERROR;
`else
      DATA_LO: if (accept) nextState = lastWord ? DRAIN : DATA_HI;
`endif
      DRAIN:   nextState = RUN;
      RUN:     if (start) nextState = LEN_HI;
      ERROR:   if (start) nextState = LEN_HI;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from nextState so they line up with the state
  // they describe; cpu_reset rises at the same edge a restart leaves RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wordIdx   <= '0;
      lastIdx   <= '0;
      lenHi     <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
      chkHi     <= '0;
`endif
    end else begin
      state     <= nextState;
      rx_ready  <= isRxState(nextState);
      busy      <= isBusyState(nextState);
      done      <= (nextState == RUN);
      err       <= (nextState == ERROR);
      cpu_reset <= (nextState != RUN);
      rom_we    <= 1'b0;
      if (accept) begin
        case (state)
          LEN_HI: lenHi <= rx_data;
          LEN_LO: begin
            if (!lenBad) begin
              wordIdx <= '0;
              lastIdx <= ADDR_W'(lenFull - 16'd1);
            end
          end
          DATA_LO: begin
            rom_we    <= 1'b1;
            rom_addr  <= wordIdx;
            rom_wdata <= asmWord;
            if (!lastWord) wordIdx <= wordIdx + 1'b1;
          end
`ifdef HACK_BOOT_CHECKSUM_EN
          CHK_HI: chkHi <= rx_data;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - self-checking bench for hack_boot_loader
// Purpose: drives directed and random images through the byte stream and
//   compares memory writes and status outputs against a behavioural model.
// Ports: none (top-level bench).
// Build option: HACK_BOOT_CHECKSUM_EN adds checksum bytes to every image.
module tb_hack_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        rom_we;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int vectorCount = 0;
  int missCount = 0;

  logic [30:0] writeLog[$];
  logic        prevWe = 1'b0;
  int          longPulse = 0;

  always #5 clock = ~clock;

  hack_boot_loader #(.ADDR_W(15), .PROG_WORDS(32768)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .rom_we    (rom_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Write monitor: every strobed cycle is one write; a strobe seen on two
  // consecutive cycles is a stretched pulse.
  always @(negedge clock) begin
    if (rom_we) writeLog.push_back({rom_addr, rom_wdata});
    if (rom_we && prevWe) longPulse <= longPulse + 1;
    prevWe <= rom_we;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and returns just after the
  // edge that accepts it.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt;
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      checkVal("rx_ready_in_gap", 32'(rx_ready), 32'd1);
    end
    @(negedge clock);
    rx_data = b;
    rx_valid = 1'b1;
    waitCnt = 0;
    while (!rx_ready && waitCnt < 100) begin
      @(negedge clock);
      waitCnt++;
    end
    if (waitCnt >= 100) checkVal("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  // Model: a length of 0 or above 32768 is rejected with no writes;
  // otherwise word i lands at address i, and (with checksum) the image runs
  // only if the sent checksum equals the 16-bit sum of the words.
  task automatic loadImage(input logic [15:0] n, input logic [15:0] words[$],
                           input int gMin, input int gMax, input bit badChk, input bit startMid);
    int  base;
    int  nExp;
    int  nGot;
    bit  lenBad;
    bit  expOk;
`ifdef HACK_BOOT_CHECKSUM_EN
    logic [15:0] sum;
    logic [15:0] chk;
    sum = 16'd0;
`endif
    base = writeLog.size();
    pulseStart();
    sendByte(n[15:8], $urandom_range(gMax, gMin));
    sendByte(n[7:0], $urandom_range(gMax, gMin));
    lenBad = (n == 16'd0) || (32'(n) > 32'd32768);
    if (!lenBad) begin
      for (int i = 0; i < int'(n); i++) begin
        if (startMid && i == 0) pulseStart();
        sendByte(words[i][15:8], $urandom_range(gMax, gMin));
        sendByte(words[i][7:0], $urandom_range(gMax, gMin));
`ifdef HACK_BOOT_CHECKSUM_EN
        sum = sum + words[i];
`endif
      end
`ifdef HACK_BOOT_CHECKSUM_EN
      chk = sum + 16'(badChk);
      sendByte(chk[15:8], $urandom_range(gMax, gMin));
      sendByte(chk[7:0], $urandom_range(gMax, gMin));
`endif
    end
    expOk = !lenBad;
`ifdef HACK_BOOT_CHECKSUM_EN
    expOk = expOk && !badChk;
`endif
    if (expOk) begin
      checkVal("drain_busy", 32'(busy), 32'd1);
      checkVal("drain_cpu_reset", 32'(cpu_reset), 32'd1);
      @(posedge clock);
      #1;
      checkVal("run_cpu_reset", 32'(cpu_reset), 32'd0);
      checkVal("run_done", 32'(done), 32'd1);
      checkVal("run_err", 32'(err), 32'd0);
      checkVal("run_busy", 32'(busy), 32'd0);
      checkVal("run_rx_ready", 32'(rx_ready), 32'd0);
    end else begin
      checkVal("error_err", 32'(err), 32'd1);
      checkVal("error_cpu_reset", 32'(cpu_reset), 32'd1);
      checkVal("error_busy", 32'(busy), 32'd0);
      checkVal("error_done", 32'(done), 32'd0);
    end
    repeat (2) @(negedge clock);
    nExp = lenBad ? 0 : int'(n);
    nGot = writeLog.size() - base;
    checkVal("write_count", 32'(nGot), 32'(nExp));
    for (int i = 0; i < nGot && i < nExp; i++) begin
      checkVal("write_addr", 32'(writeLog[base + i][30:16]), 32'(i));
      checkVal("write_data", 32'(writeLog[base + i][15:0]), 32'(words[i]));
    end
  endtask

  initial begin
    logic [15:0] w[$];
    int          n;
    int          base;

    repeat (3) @(negedge clock);
    checkVal("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkVal("reset_rx_ready", 32'(rx_ready), 32'd0);
    checkVal("reset_rom_we", 32'(rom_we), 32'd0);
    checkVal("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkVal("reset_rom_wdata", 32'(rom_wdata), 32'd0);
    checkVal("reset_busy", 32'(busy), 32'd0);
    checkVal("reset_done", 32'(done), 32'd0);
    checkVal("reset_err", 32'(err), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic two-word image, back-to-back bytes.
    w = '{16'hEA88, 16'hFC10};
    loadImage(16'd2, w, 0, 0, 1'b0, 1'b0);

    // Same image with 3 idle cycles before every byte.
    loadImage(16'd2, w, 3, 3, 1'b0, 1'b0);

    // Rejected lengths, then recovery with a valid one-word image.
    loadImage(16'd0, w, 0, 1, 1'b0, 1'b0);
    loadImage(16'h8001, w, 0, 1, 1'b0, 1'b0);
    w = '{16'h1234};
    loadImage(16'd1, w, 0, 0, 1'b0, 1'b0);

    // Maximum length is accepted; restart from RUN, then async reset while
    // waiting for the low byte of the first word.
    base = writeLog.size();
    pulseStart();
    checkVal("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    sendByte(8'h80, 0);
    sendByte(8'h00, 0);
    checkVal("maxlen_err", 32'(err), 32'd0);
    checkVal("maxlen_busy", 32'(busy), 32'd1);
    checkVal("maxlen_rx_ready", 32'(rx_ready), 32'd1);
    sendByte(8'h5A, 0);
    #2;
    reset = 1'b0;
    #1;
    checkVal("async_cpu_reset", 32'(cpu_reset), 32'd1);
    checkVal("async_busy", 32'(busy), 32'd0);
    checkVal("async_done", 32'(done), 32'd0);
    checkVal("async_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkVal("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    checkVal("idle_busy", 32'(busy), 32'd0);
    checkVal("aborted_write_count", 32'(writeLog.size() - base), 32'd0);

    // start during DATA_HI must not restart the load.
    w = '{16'h0F0F, 16'hA5A5, 16'h8001};
    loadImage(16'd3, w, 0, 1, 1'b0, 1'b1);

`ifdef HACK_BOOT_CHECKSUM_EN
    w = '{16'h0005};
    loadImage(16'd1, w, 0, 0, 1'b0, 1'b0);
    loadImage(16'd1, w, 0, 0, 1'b1, 1'b0);
`endif

    // Random images with random gaps.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(6, 1);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      loadImage(16'(n), w, 0, 3, 1'($urandom_range(1, 0)), 1'b0);
    end

    checkVal("rom_we_pulse_width", 32'(longPulse), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
